// File: rtl/seq_detect_mealy_param_pkg.sv
// -----------------------------------------------------------------------------
// seq_detect_pkg
// Shared types and helpers for the parameterised Mealy pattern detector.
//   state_e    : detector FSM encoding (2 bits)
//   clamp_len  : limits a requested pattern length to the supported maximum
//   low_mask   : MASK_W-bit mask with the low 'len' bits set
// MASK_W bounds MAX_LEN; the detector supports patterns up to 64 bits.
// -----------------------------------------------------------------------------
package seq_detect_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_ARMED = 2'd2
    } state_e;

    localparam int MASK_W = 64;

    function automatic int clamp_len(input int len, input int max_len);
        int res;
        if (len > max_len) begin
            res = max_len;
        end else begin
            res = len;
        end
        return res;
    endfunction

    function automatic logic [MASK_W-1:0] low_mask(input int len);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_W; i++) begin
            if (i < len) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_detect_mealy_param_if.sv
// -----------------------------------------------------------------------------
// seq_detect_mealy_param_if
// Bundles the serial stream, pattern programming and result signals of the
// detector. clk/clr are kept outside as plain ports of the detector.
//   i_x, i_x_valid        : serial bit and its qualifier
//   i_pat_load            : one-cycle strobe capturing i_pat_in/i_pat_len/i_overlap
//   i_pat_in [MAX_LEN]    : pattern, bit len-1 arrives first, bit 0 last
//   i_pat_len [LEN_W]     : active length (0 disables, >MAX_LEN clamps)
//   i_overlap             : 1 = overlapping matches, 0 = flush after match
//   o_y / o_y_reg         : combinational match / one-cycle registered copy
//   o_armed               : detector is in S_ARMED
//   o_match_cnt [CNT_W]   : saturating match count (SEQ_DETECT_MATCH_CNT_EN)
// Modports: master drives the inputs (stream source), slave is the detector.
// -----------------------------------------------------------------------------
interface seq_detect_mealy_param_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = 8
);
    logic               i_x;
    logic               i_x_valid;
    logic               i_pat_load;
    logic [MAX_LEN-1:0] i_pat_in;
    logic [LEN_W-1:0]   i_pat_len;
    logic               i_overlap;
    logic               o_y;
    logic               o_y_reg;
    logic               o_armed;
    logic [CNT_W-1:0]   o_match_cnt;

    modport master (
        output i_x, i_x_valid, i_pat_load, i_pat_in, i_pat_len, i_overlap,
        input  o_y, o_y_reg, o_armed, o_match_cnt
    );

    modport slave (
        input  i_x, i_x_valid, i_pat_load, i_pat_in, i_pat_len, i_overlap,
        output o_y, o_y_reg, o_armed, o_match_cnt
    );
endinterface

// File: rtl/seq_detect_mealy_param_match_cmp.sv
// -----------------------------------------------------------------------------
// seq_match_cmp
// Combinational masked compare: o_eq is high when the low i_len bits of
// i_cand equal the low i_len bits of i_pat. Higher bits are don't-care.
//   i_cand [MAX_LEN] : candidate window (newest bit at bit 0)
//   i_pat  [MAX_LEN] : programmed pattern
//   i_len  [LEN_W]   : compare length (already clamped by the caller)
//   o_eq             : masked equality
// -----------------------------------------------------------------------------
module seq_match_cmp
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic [MAX_LEN-1:0] i_cand,
    input  logic [MAX_LEN-1:0] i_pat,
    input  logic [LEN_W-1:0]   i_len,
    output logic               o_eq
);
    logic [MASK_W-1:0] w_mask;
    logic [MASK_W-1:0] w_diff;

    // The compare runs at the full mask width so every mask bit is consumed.
    assign w_mask = low_mask(int'(i_len));
    assign w_diff = MASK_W'(i_cand ^ i_pat);
    assign o_eq   = ((w_diff & w_mask) == {MASK_W{1'b0}});
endmodule

// File: rtl/seq_detect_mealy_param.sv
// -----------------------------------------------------------------------------
// seq_detect_mealy_param
// Runtime-programmable Mealy serial-pattern detector.
//   clk  : rising-edge clock
//   clr  : synchronous active-high reset, highest priority
//   bus  : seq_detect_mealy_param_if.slave (stream, programming, results)
// Optional feature macro: SEQ_DETECT_MATCH_CNT_EN enables the saturating
// match counter; when undefined o_match_cnt is tied to 0 with no flops.
// -----------------------------------------------------------------------------
module seq_detect_mealy_param
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic clr,
    seq_detect_mealy_param_if.slave bus
);
    state_e             r_state;
    state_e             w_state_nxt;
    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;
    logic               r_ovl;
    // The oldest history bit can never enter a MAX_LEN-bit window that also
    // holds the incoming bit, so only MAX_LEN-1 bits are stored.
    logic [MAX_LEN-2:0] r_hist;
    logic [MAX_LEN-2:0] w_hist_nxt;
    logic [LEN_W-1:0]   r_fill;
    logic [LEN_W-1:0]   w_fill_nxt;
    logic [LEN_W-1:0]   w_fill_inc;
    logic [LEN_W-1:0]   w_len_load;
    logic [MAX_LEN-1:0] w_cand;
    logic               w_eq;
    logic               w_y;
    logic               r_y;

    assign w_cand     = {r_hist, bus.i_x};
    assign w_len_load = LEN_W'(clamp_len(int'(bus.i_pat_len), MAX_LEN));

    seq_match_cmp #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_cmp (
        .i_cand (w_cand),
        .i_pat  (r_pat),
        .i_len  (r_len),
        .o_eq   (w_eq)
    );

    // A load cycle discards the incoming bit, so it can never match.
    assign w_y = bus.i_x_valid & ~bus.i_pat_load & (r_state == S_ARMED) & w_eq;

    // Next-state, history and fill computation.
    always_comb begin
        w_state_nxt = r_state;
        w_hist_nxt  = r_hist;
        w_fill_nxt  = r_fill;
        if (r_fill == LEN_W'(MAX_LEN)) begin
            w_fill_inc = r_fill;
        end else begin
            w_fill_inc = r_fill + LEN_W'(1);
        end

        if (bus.i_pat_load) begin
            w_hist_nxt = '0;
            w_fill_nxt = '0;
            if (w_len_load == LEN_W'(0)) begin
                w_state_nxt = S_IDLE;
            end else if (w_len_load == LEN_W'(1)) begin
                w_state_nxt = S_ARMED;
            end else begin
                w_state_nxt = S_FILL;
            end
        end else if (bus.i_x_valid) begin
            if (w_y && !r_ovl) begin
                // Non-overlap match: forget history and start a fresh window.
                w_hist_nxt = '0;
                w_fill_nxt = '0;
                if (r_len == LEN_W'(1)) begin
                    w_state_nxt = S_ARMED;
                end else begin
                    w_state_nxt = S_FILL;
                end
            end else begin
                w_hist_nxt = w_cand[MAX_LEN-2:0];
                w_fill_nxt = w_fill_inc;
                case (r_state)
                    S_IDLE: begin
                        w_state_nxt = S_IDLE;
                    end
                    S_FILL: begin
                        // r_len >= 2 whenever S_FILL is reached.
                        if (w_fill_inc >= (r_len - LEN_W'(1))) begin
                            w_state_nxt = S_ARMED;
                        end else begin
                            w_state_nxt = S_FILL;
                        end
                    end
                    S_ARMED: begin
                        w_state_nxt = S_ARMED;
                    end
                    default: begin
                        w_state_nxt = S_IDLE;
                    end
                endcase
            end
        end else begin
            w_state_nxt = r_state;
            w_hist_nxt  = r_hist;
            w_fill_nxt  = r_fill;
        end
    end

    // State, history, configuration and registered match output.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_hist  <= '0;
            r_fill  <= '0;
            r_pat   <= '0;
            r_len   <= '0;
            r_ovl   <= 1'b1;
            r_y     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hist  <= w_hist_nxt;
            r_fill  <= w_fill_nxt;
            r_y     <= w_y;
            if (bus.i_pat_load) begin
                r_pat <= bus.i_pat_in;
                r_len <= w_len_load;
                r_ovl <= bus.i_overlap;
            end else begin
                r_pat <= r_pat;
                r_len <= r_len;
                r_ovl <= r_ovl;
            end
        end
    end

`ifdef SEQ_DETECT_MATCH_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    // Saturating count of match cycles, cleared by reset and by a load.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_cnt <= '0;
        end else if (bus.i_pat_load) begin
            r_cnt <= '0;
        end else if (w_y && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign bus.o_match_cnt = r_cnt;
`else
    assign bus.o_match_cnt = {CNT_W{1'b0}};
`endif

    assign bus.o_y     = w_y;
    assign bus.o_y_reg = r_y;
    assign bus.o_armed = (r_state == S_ARMED);
endmodule

// File: tb/tb_seq_detect_mealy_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_mealy_param
// Directed bench for seq_detect_mealy_param (MAX_LEN=8, CNT_W=2). Inputs are
// driven on the falling edge; y is sampled 1 ns after driving, y_reg/armed/
// match_cnt 1 ns after the rising edge. Counter expectations follow
// SEQ_DETECT_MATCH_CNT_EN (0 when the macro is undefined).
// -----------------------------------------------------------------------------
module tb_seq_detect_mealy_param;
    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 2;

    logic clk = 1'b0;
    logic clr;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    seq_detect_mealy_param_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus_if ();

    seq_detect_mealy_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus_if)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_cnt(input int n);
`ifdef SEQ_DETECT_MATCH_CNT_EN
        return (n > 3) ? 3 : n;
`else
        return 0 * n;
`endif
    endfunction

    // One stream cycle: drive, check y, clock, check y_reg and armed.
    task automatic bit_in(input logic b, input logic v, input logic ey, input logic ea, input string tag);
        bus_if.i_x       = b;
        bus_if.i_x_valid = v;
        #1;
        check_val({tag, "_y"}, 32'(bus_if.o_y), 32'(ey));
        @(posedge clk);
        #1;
        check_val({tag, "_yr"}, 32'(bus_if.o_y_reg), 32'(ey));
        check_val({tag, "_arm"}, 32'(bus_if.o_armed), 32'(ea));
        @(negedge clk);
        bus_if.i_x_valid = 1'b0;
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] len, input logic ov,
                        input logic xv, input logic xb, input logic ea, input string tag);
        bus_if.i_pat_load = 1'b1;
        bus_if.i_pat_in   = p;
        bus_if.i_pat_len  = len;
        bus_if.i_overlap  = ov;
        bus_if.i_x        = xb;
        bus_if.i_x_valid  = xv;
        #1;
        check_val({tag, "_y"}, 32'(bus_if.o_y), 32'd0);
        @(posedge clk);
        #1;
        check_val({tag, "_yr"}, 32'(bus_if.o_y_reg), 32'd0);
        check_val({tag, "_arm"}, 32'(bus_if.o_armed), 32'(ea));
        check_val({tag, "_cnt"}, 32'(bus_if.o_match_cnt), 32'd0);
        @(negedge clk);
        bus_if.i_pat_load = 1'b0;
        bus_if.i_x_valid  = 1'b0;
    endtask

    // Feeds n bits MSB first; optional invalid gap cycles with x inverted.
    task automatic run_stream(input logic [15:0] s, input logic [15:0] ey, input logic [15:0] ea,
                              input int n, input logic gaps, input string tag);
        for (int i = 0; i < n; i++) begin
            bit_in(s[n-1-i], 1'b1, ey[n-1-i], ea[n-1-i], $sformatf("%s%0d", tag, i));
            if (gaps) begin
                bit_in(~s[n-1-i], 1'b0, 1'b0, ea[n-1-i], $sformatf("%s_gap%0d", tag, i));
            end
        end
    endtask

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // Directed scenario sequence.
    initial begin
        clr               = 1'b1;
        bus_if.i_x        = 1'b0;
        bus_if.i_x_valid  = 1'b0;
        bus_if.i_pat_load = 1'b0;
        bus_if.i_pat_in   = 8'h00;
        bus_if.i_pat_len  = 4'd0;
        bus_if.i_overlap  = 1'b0;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        #1;
        check_val("rst_y",   32'(bus_if.o_y), 32'd0);
        check_val("rst_yr",  32'(bus_if.o_y_reg), 32'd0);
        check_val("rst_arm", 32'(bus_if.o_armed), 32'd0);
        check_val("rst_cnt", 32'(bus_if.o_match_cnt), 32'd0);
        @(negedge clk);
        bit_in(1'b1, 1'b1, 1'b0, 1'b0, "idle");

        // Overlapping matches on bits 4 and 7, armed from bit 3.
        load(8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, "ld_ov");
        run_stream(16'b1011011, 16'b0001001, 16'b0011111, 7, 1'b0, "ov");
        check_val("ov_cnt", 32'(bus_if.o_match_cnt), 32'(exp_cnt(2)));

        // Non-overlap: flush after bit 4, re-armed on bit 7 without a match.
        load(8'b0000_1011, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, "ld_nov");
        run_stream(16'b1011011, 16'b0001000, 16'b0010001, 7, 1'b0, "nov");
        check_val("nov_cnt", 32'(bus_if.o_match_cnt), 32'(exp_cnt(1)));

        // Invalid gap cycles must not change the outcome.
        load(8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, "ld_gap");
        run_stream(16'b1011011, 16'b0001001, 16'b0011111, 7, 1'b1, "gp");
        check_val("gap_cnt", 32'(bus_if.o_match_cnt), 32'(exp_cnt(2)));

        // Length 0 disables detection.
        load(8'b0000_1011, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, "ld_dis");
        run_stream(16'b1011011, 16'b0, 16'b0, 7, 1'b0, "dis");

        // Load mid-stream with a bit that would have matched the old pattern.
        load(8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, "ld_m0");
        run_stream(16'b101, 16'b000, 16'b001, 3, 1'b0, "m0");
        load(8'b0000_0011, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, "ld_mid");
        bit_in(1'b1, 1'b1, 1'b0, 1'b1, "mid1");
        bit_in(1'b1, 1'b1, 1'b1, 1'b1, "mid2");
        check_val("mid_cnt", 32'(bus_if.o_match_cnt), 32'(exp_cnt(1)));

        // Reset wins over a simultaneous load and matching bit.
        clr               = 1'b1;
        bus_if.i_pat_load = 1'b1;
        bus_if.i_pat_in   = 8'b0000_0011;
        bus_if.i_pat_len  = 4'd2;
        bus_if.i_overlap  = 1'b1;
        bus_if.i_x        = 1'b1;
        bus_if.i_x_valid  = 1'b1;
        #1;
        check_val("clr_y", 32'(bus_if.o_y), 32'd0);
        @(posedge clk);
        #1;
        check_val("clr_yr",  32'(bus_if.o_y_reg), 32'd0);
        check_val("clr_arm", 32'(bus_if.o_armed), 32'd0);
        check_val("clr_cnt", 32'(bus_if.o_match_cnt), 32'd0);
        @(negedge clk);
        clr               = 1'b0;
        bus_if.i_pat_load = 1'b0;
        bus_if.i_x_valid  = 1'b0;
        run_stream(16'b111, 16'b000, 16'b000, 3, 1'b0, "pclr");

        // Length 15 clamps to 8: 0xA5 matches on the 8th bit.
        load(8'hA5, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0, "ld_clamp");
        run_stream(16'b10100101, 16'b00000001, 16'b00000011, 8, 1'b0, "clamp");

        // L=1 overlapping matches saturate the 2-bit counter at 3.
        load(8'h01, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, "ld_sat");
        run_stream(16'b111110, 16'b111110, 16'b111111, 6, 1'b0, "sat");
        check_val("sat_cnt", 32'(bus_if.o_match_cnt), 32'(exp_cnt(5)));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
